serial_add_sub: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor; next generation of the 2-bit ripple add/sub.

---
 rtl/serial_add_sub.sv | 184 ++++++++++++++++++
 tb/tb_serial_add_sub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor.
// Each operation takes WIDTH/DIGIT RUN cycles, handling DIGIT bits per cycle
// from the LSB digit upward. A registered carry links consecutive digits.
// Operands are shifted right one digit per cycle. The result is shifted in
// from the top, so after the last digit it sits fully aligned.

// Single DIGIT-bit ripple-carry slice.
// Also exposes the carry into its top bit, which is used for signed overflow.
module serial_add_sub_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             c_msb,
  output logic             cout
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_msb = c[DIGIT-1];
  assign cout  = c[DIGIT];
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NCYC = WIDTH / DIGIT;
  localparam int KW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_c_msb;
  logic             dig_cout;
  logic             last_dig;

  // The current digit is always the low DIGIT bits of the shifting operands.
  serial_add_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (cy_q),
    .sum   (dig_sum),
    .c_msb (dig_c_msb),
    .cout  (dig_cout)
  );

  assign last_dig = (k_q == KW'(NCYC - 1));

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cy_d        = cy_q;
    k_d         = k_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction becomes A + ~B + 1: invert B now, seed the carry with sub.
          a_d        = a;
          b_d        = b ^ {WIDTH{sub}};
          cy_d       = sub;
          k_d        = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        cy_d     = dig_cout;
        result_d = (result_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        k_d      = k_q + 1'b1;
        if (last_dig) begin
          carry_out_d = dig_cout;
          overflow_d  = dig_c_msb ^ dig_cout;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // Outputs hold here for as long as the consumer stalls.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State registers. Reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cy_q        <= 1'b0;
      k_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cy_q        <= cy_d;
      k_q         <= k_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub.
// Four configurations are covered: 8/2, 8/1, 8/8 and 16/4.
module tb_serial_add_sub;
  logic        clk;
  logic        rst;
  logic        out_ready;
  logic [3:0]  iv;
  logic [15:0] a_bus, b_bus;
  logic        sub_in;
  wire  [3:0]  ir, ov, co, vf, bz;
  wire  [7:0]  r0, r1, r2;
  wire  [15:0] r3;
  int          n_chk;
  int          n_fail;

  serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .sub(sub_in), .out_valid(ov[0]), .out_ready(out_ready), .result(r0), .carry_out(co[0]),
    .overflow(vf[0]), .busy(bz[0]));
  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .sub(sub_in), .out_valid(ov[1]), .out_ready(out_ready), .result(r1), .carry_out(co[1]),
    .overflow(vf[1]), .busy(bz[1]));
  serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .sub(sub_in), .out_valid(ov[2]), .out_ready(out_ready), .result(r2), .carry_out(co[2]),
    .overflow(vf[2]), .busy(bz[2]));
  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_bus), .b(b_bus),
    .sub(sub_in), .out_valid(ov[3]), .out_ready(out_ready), .result(r3), .carry_out(co[3]),
    .overflow(vf[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation on instance idx: accept, latency, busy, result/flags and release checks.
  task automatic run_op(input int idx, input logic [15:0] av_in, input logic [15:0] bv_in,
                        input logic sv, input string nm);
    int          w, lat, n;
    logic [15:0] mask, av, bv, bb, exp_r, got_r;
    logic [16:0] full;
    logic        exp_c, exp_v;
    w     = (idx == 3) ? 16 : 8;
    lat   = (idx == 1) ? 8 : (idx == 2) ? 1 : 4;
    mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
    av    = av_in & mask;
    bv    = bv_in & mask;
    bb    = (sv ? ~bv : bv) & mask;
    full  = {1'b0, av} + {1'b0, bb} + 17'(sv);
    exp_r = full[15:0] & mask;
    exp_c = (w == 16) ? full[16] : full[8];
    exp_v = (w == 16) ? ((av[15] == bb[15]) && (exp_r[15] != av[15]))
                      : ((av[7] == bb[7]) && (exp_r[7] != av[7]));
    n = 0;
    while (!ir[idx] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_chk++;
    if (ir[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s/%0d ready_timeout in_ready=%b want 1", nm, idx, ir[idx]);
      return;
    end
    a_bus = av; b_bus = bv; sub_in = sv; iv[idx] = 1'b1;
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    n_chk++;
    if (bz[idx] !== 1'b1 || ir[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s/%0d busy_after_accept busy=%b in_ready=%b want 1/0", nm, idx, bz[idx], ir[idx]);
    end
    n = 0;
    while (!ov[idx] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_chk++;
    if (n !== lat) begin
      n_fail++;
      $display("FAIL %s/%0d latency got %0d want %0d", nm, idx, n, lat);
    end
    case (idx)
      0: got_r = {8'h00, r0};
      1: got_r = {8'h00, r1};
      2: got_r = {8'h00, r2};
      default: got_r = r3;
    endcase
    n_chk++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL %s/%0d result got %h want %h (a=%h b=%h sub=%b)", nm, idx, got_r, exp_r, av, bv, sv);
    end
    n_chk++;
    if (co[idx] !== exp_c) begin
      n_fail++;
      $display("FAIL %s/%0d carry_out got %b want %b (a=%h b=%h sub=%b)", nm, idx, co[idx], exp_c, av, bv, sv);
    end
    n_chk++;
    if (vf[idx] !== exp_v) begin
      n_fail++;
      $display("FAIL %s/%0d overflow got %b want %b (a=%h b=%h sub=%b)", nm, idx, vf[idx], exp_v, av, bv, sv);
    end
    if (out_ready) begin
      @(posedge clk); #1;
      n_chk++;
      if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1 || bz[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s/%0d release out_valid=%b in_ready=%b busy=%b want 0/1/0", nm, idx, ov[idx], ir[idx], bz[idx]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; out_ready = 1'b1; a_bus = '0; b_bus = '0; sub_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++;
    if (ir !== 4'hF || ov !== 4'h0 || bz !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b want 1111/0000/0000", ir, ov, bz);
    end
    n_chk++;
    if (r0 !== 8'h00 || r3 !== 16'h0000 || co !== 4'h0 || vf !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data result=%h/%h carry=%b ovf=%b want 0", r0, r3, co, vf);
    end
  endtask

  task automatic test_vectors(input int idx);
    run_op(idx, 16'h0005, 16'h0003, 1'b0, "add_5_3");
    run_op(idx, 16'h0003, 16'h0005, 1'b1, "sub_3_5");
    run_op(idx, 16'h0080, 16'h0001, 1'b1, "sub_80_1");
    run_op(idx, 16'h007F, 16'h0001, 1'b0, "add_7f_1");
    run_op(idx, 16'h00FF, 16'h0001, 1'b0, "add_ff_1");
  endtask

  task automatic test_w16_edges();
    run_op(3, 16'h7FFF, 16'h0001, 1'b0, "w16_add_ovf");
    run_op(3, 16'hFFFF, 16'h0001, 1'b0, "w16_add_wrap");
    run_op(3, 16'h8000, 16'h0001, 1'b1, "w16_sub_ovf");
    run_op(3, 16'h1234, 16'h5678, 1'b1, "w16_sub_borrow");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    run_op(0, 16'h007F, 16'h0001, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      a_bus = 16'($urandom); b_bus = 16'($urandom); sub_in = ~sub_in; iv[0] = ~iv[0];
      @(posedge clk); #1;
      n_chk++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || r0 !== 8'h80 || co[0] !== 1'b0 || vf[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d out_valid=%b in_ready=%b result=%h c=%b v=%b want 1/0/80/0/1",
                 i, ov[0], ir[0], r0, co[0], vf[0]);
      end
    end
    iv[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a_bus = 16'h0055; b_bus = 16'h0011; sub_in = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || r0 !== 8'h00 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid out_valid=%b busy=%b result=%h in_ready=%b want 0/0/00/1", ov[0], bz[0], r0, ir[0]);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_emit out_valid_cycles=%0d want 0", seen);
    end
    run_op(0, 16'h0010, 16'h0020, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int idx = 0; idx < 4; idx++) begin
      for (int j = 0; j < 25; j++) begin
        run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom), "rand");
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_vectors(0);
    test_backpressure();
    test_reset_mid_run();
    test_vectors(1);
    test_vectors(2);
    test_vectors(3);
    test_w16_edges();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
